// File: rtl/spike_enc_pkg.sv
// spike_enc_pkg: shared FSM states and the slot-width helper for the spike time encoder.
package spike_enc_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  function automatic int time_w(input int window);
    return $clog2(window) + 1;
  endfunction
endpackage

// File: rtl/spike_time_lane.sv
// spike_time_lane: per-line first-spike capture (seen flag plus slot register).
module spike_time_lane #(
  parameter int WINDOW = 8,
  parameter int TIME_W = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              spike,
  input  logic [TIME_W-1:0] t,
  output logic [TIME_W-1:0] slot,
  output logic              seen
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      seen <= 1'b0;
      slot <= TIME_W'(WINDOW);
    end else if (en && spike && !seen) begin
      seen <= 1'b1;
      slot <= t;
    end
  end
endmodule

// File: rtl/spike_time_encoder.sv
// spike_time_encoder: time-to-first-spike encoder, one window of WINDOW slots per grst toggle.
// Defining SPIKE_ENC_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module spike_time_encoder
  import spike_enc_pkg::*;
#(
  parameter int P = 64,
  parameter int WINDOW = 8,
  localparam int TIME_W = time_w(WINDOW)
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       grst,
  input  logic                       start_count,
  input  logic [P-1:0]               spike_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [P-1:0][TIME_W-1:0]   spike_time,
  output logic [P-1:0]               spike_seen
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
  ,output logic [7:0]                overrun_cnt
`endif
);
  state_t state;
  logic grst_q;
  logic [TIME_W-1:0] t;
  logic phase_edge, clear, en;
  assign phase_edge = grst != grst_q;
  // An edge in IDLE opens a window, an edge in SCAN restarts it; in HOLD it is an overrun.
  assign clear = phase_edge && start_count && state != HOLD;
  assign en = state == SCAN && start_count;
  for (genvar i = 0; i < P; i++) begin : g_lane
    spike_time_lane #(.WINDOW(WINDOW), .TIME_W(TIME_W)) u_lane (
      .clk(clk), .rst(rst), .clear(clear), .en(en), .spike(spike_in[i]), .t(t),
      .slot(spike_time[i]), .seen(spike_seen[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      out_valid <= 1'b0;
      grst_q <= grst;
    end else begin
      grst_q <= grst;
      case (state)
        IDLE: if (phase_edge && start_count) begin
          state <= SCAN;
          t <= '0;
        end
        SCAN: if (!start_count) begin
          state <= IDLE;
          t <= '0;
        end else if (phase_edge) begin
          t <= '0;
        end else if (t == TIME_W'(WINDOW - 1)) begin
          state <= HOLD;
          t <= '0;
          out_valid <= 1'b1;
        end else begin
          t <= t + 1'b1;
        end
        HOLD: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) overrun_cnt <= '0;
    else if (state == HOLD && phase_edge && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_spike_time_encoder.sv
// tb_spike_time_encoder: directed table-driven bench for spike_time_encoder with P=4, WINDOW=8.
module tb_spike_time_encoder;
  typedef struct packed {
    logic [7:0][3:0] slots;
    logic [3:0][3:0] times;
    logic [3:0]      seen;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, grst = 1'b0, start_count = 1'b0, out_ready = 1'b0;
  logic [3:0] spike_in = '0;
  logic out_valid;
  logic [3:0][3:0] spike_time;
  logic [3:0] spike_seen;
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif
  int tests = 0, fails = 0;
  vec_t v [5];
  spike_time_encoder #(.P(4), .WINDOW(8)) dut (
    .clk(clk), .rst(rst), .grst(grst), .start_count(start_count), .spike_in(spike_in),
    .out_valid(out_valid), .out_ready(out_ready), .spike_time(spike_time), .spike_seen(spike_seen)
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Toggle grst now (edge detected this cycle), replay slots, wait for out_valid.
  task automatic run_window(input string name, input vec_t w);
    int lat;
    lat = -1;
    grst = ~grst;
    start_count = 1'b1;
    spike_in = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (out_valid) begin
        lat = n;
        break;
      end
      spike_in = (n <= 8) ? w.slots[n-1] : 4'b0;
    end
    spike_in = '0;
    chk({name, " latency"}, lat, 9);
    chk({name, " times"}, spike_time, w.times);
    chk({name, " seen"}, spike_seen, w.seen);
  endtask
  task automatic handshake(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, " valid drop"}, out_valid, 0);
  endtask
  initial begin
    logic bad;
    for (int i = 0; i < 5; i++) v[i] = '0;
    v[0].slots[3] = 4'b0001; v[0].slots[5] = 4'b0001;
    v[0].times = {4'd8, 4'd8, 4'd8, 4'd3}; v[0].seen = 4'b0001;
    v[1].slots[0] = 4'b0010; v[1].slots[7] = 4'b0100;
    v[1].times = {4'd8, 4'd7, 4'd0, 4'd8}; v[1].seen = 4'b0110;
    for (int k = 0; k < 8; k++) v[2].slots[k] = 4'b1111;
    v[2].times = {4'd0, 4'd0, 4'd0, 4'd0}; v[2].seen = 4'b1111;
    v[3].slots[1] = 4'b0010; v[3].slots[2] = 4'b1000; v[3].slots[4] = 4'b0010; v[3].slots[6] = 4'b0001;
    v[3].times = {4'd2, 4'd8, 4'd1, 4'd6}; v[3].seen = 4'b1011;
    v[4].times = {4'd8, 4'd8, 4'd8, 4'd8}; v[4].seen = 4'b0000;
    step(); step();
    rst = 1'b0;
    chk("reset valid", out_valid, 0);
    chk("reset times", spike_time, 16'h8888);
    chk("reset seen", spike_seen, 0);
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
    chk("reset overrun", overrun_cnt, 0);
`endif
    step();
    for (int i = 0; i < 5; i++) begin
      run_window($sformatf("vec%0d", i), v[i]);
      handshake($sformatf("vec%0d", i));
      step();
    end
    // Overrun: consumer stalls 20 cycles while grst toggles once.
    run_window("stall", v[0]);
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (n == 5) grst = ~grst;
      if (!out_valid || spike_time !== v[0].times || spike_seen !== v[0].seen) bad = 1'b1;
    end
    chk("stall hold stable", bad, 0);
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
    chk("stall overrun", overrun_cnt, 1);
`endif
    handshake("stall");
    step();
    // Restart: second edge at t=4 discards the partial window.
    grst = ~grst;
    start_count = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      spike_in = (n == 1) ? 4'b1111 : 4'b0;
    end
    run_window("restart", v[3]);
    handshake("restart");
    step();
    // Reset at t=2 mid-SCAN.
    grst = ~grst;
    for (int n = 1; n <= 3; n++) begin
      step();
      spike_in = (n == 1) ? 4'b0001 : 4'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midscan rst valid", out_valid, 0);
    chk("midscan rst times", spike_time, 16'h8888);
    chk("midscan rst seen", spike_seen, 0);
    step();
    run_window("after rst", v[1]);
    handshake("after rst");
    step();
    // start_count drop at t=5 aborts without output.
    grst = ~grst;
    for (int n = 1; n <= 6; n++) step();
    start_count = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    chk("abort no valid", bad, 0);
    run_window("after abort", v[2]);
    handshake("after abort");
    step();
    // Edge coincident with the handshake is dropped and no new window starts.
    run_window("hs edge", v[4]);
    out_ready = 1'b1;
    grst = ~grst;
    step();
    out_ready = 1'b0;
    chk("hs edge valid drop", out_valid, 0);
`ifdef SPIKE_ENC_OVERRUN_CNT_EN
    chk("hs edge overrun", overrun_cnt, 2);
`endif
    bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    chk("hs edge no window", bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spike_time_encoder.md
SPIKE_TIME_ENCODER -- requirements
Module: spike_time_encoder

Interface
REQ-001 SHALL have parameter P, default 64: number of spike lines consumed from the upstream replay stage.
REQ-002 SHALL have parameter WINDOW, default 8: replay slots per gamma phase (half the upstream buffer depth).
REQ-003 SHALL derive localparam TIME_W = $clog2(WINDOW)+1, so that the value WINDOW means "no spike".
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port grst, input, 1 bit: gamma phase signal; each toggle opens a new window.
REQ-007 SHALL have port start_count, input, 1 bit: upstream replay active; scanning is qualified by it.
REQ-008 SHALL have port spike_in, input, P bits: replayed spike bits, one slot per cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: an encoded window is available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the window.
REQ-011 SHALL have port spike_time, output, P x TIME_W bits: first-spike slot per line, or WINDOW if the line has no spike.
REQ-012 SHALL have port spike_seen, output, P bits: the line spiked in the window.

Function
REQ-013 SHALL register grst into grst_q; a phase edge is defined as grst != grst_q.
REQ-014 SHALL implement states IDLE, SCAN, HOLD.
REQ-015 IDLE: on a phase edge with start_count=1, SHALL go to SCAN with slot counter t=0, all spike_seen=0 and all times=WINDOW.
REQ-016 SCAN: each cycle, for every line i with spike_in[i]=1 and seen[i]=0, SHALL set time[i]=t and seen[i]=1; later spikes on the same line SHALL be ignored.
REQ-017 SCAN SHALL increment t each cycle; the cycle with t=WINDOW-1 SHALL be the last sampled slot, followed by a transition to HOLD.
REQ-018 HOLD: SHALL assert out_valid, with spike_time and spike_seen stable; when out_valid && out_ready, SHALL go to IDLE the next cycle.
REQ-019 Latency: out_valid SHALL rise exactly WINDOW+1 cycles after the cycle in which the phase edge is detected.
REQ-020 A phase edge during SCAN SHALL discard the partial window and restart SCAN at t=0 with cleared state; no output is produced for the truncated window.
REQ-021 start_count=0 during SCAN SHALL abort to IDLE with no output.
REQ-022 A phase edge during HOLD SHALL count as an overrun: that window is dropped and HOLD data SHALL be unchanged.
REQ-023 A phase edge in the same cycle as the HOLD handshake SHALL also be dropped (overrun), and the state SHALL go to IDLE.
REQ-024 Outputs SHALL only change on a state transition into SCAN (clear) or during SCAN; the outputs are not valid outside HOLD.

Reset
REQ-025 On rst=1, the next edge SHALL set: state=IDLE, t=0, out_valid=0, spike_seen=0, every spike_time=WINDOW, grst_q=grst, overrun_cnt=0.
REQ-026 rst SHALL take priority over every other event, including mid-SCAN and mid-HOLD; no partial window survives.

Configuration
REQ-027 With SPIKE_ENC_OVERRUN_CNT_EN defined, SHALL add output overrun_cnt[7:0], which increments on each overrun of REQ-022/023 and saturates at 255.
REQ-028 Without SPIKE_ENC_OVERRUN_CNT_EN, SHALL have no overrun_cnt port or register, and overruns are silently dropped.

Structure
REQ-029 SHALL place the state enum (IDLE/SCAN/HOLD) and a function computing TIME_W from WINDOW in the shared package spike_enc_pkg.
REQ-030 SHALL implement the per-line capture (seen flag plus time register) as sub-module spike_time_lane, instantiated P times by a generate loop.

Verification
REQ-031 Bench with P=4, WINDOW=8: after a grst edge, spike_in[0] high at t=3 and t=5 -> spike_time[0]=3, seen[0]=1; lines with no spikes read 8 with seen=0; out_valid rises 9 cycles after edge detection.
REQ-032 Spike at t=0 on line 1 and t=7 on line 2 -> times 0 and 7, covering both window boundaries.
REQ-033 Hold out_ready=0 for 20 cycles while grst toggles -> data unchanged, out_valid stays high, overrun_cnt=1 (macro on).
REQ-034 grst edge at t=4 mid-SCAN -> no output for the first window; the second window's result arrives 9 cycles after the second edge.
REQ-035 rst asserted at t=2 of SCAN -> next cycle out_valid=0, all times=8, state IDLE; the next edge starts cleanly.
REQ-036 Drop start_count at t=5 -> return to IDLE, out_valid is never asserted.
